// File: rtl/branch_resolver.sv
// branch_resolver: closes the branch-prediction loop. Fetch predictions wait in
// a small FIFO until EX resolves them in order. Each resolve is compared with
// the oldest prediction; the result drives counter feedback, a flush/redirect
// on mispredict, and saturating statistics.
module branch_resolver #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    input  logic              pred_taken,
    input  logic [ADDR_W-1:0] pred_fallthru,
    input  logic [ADDR_W-1:0] pred_target,
    output logic              pred_ready,
    input  logic              res_valid,
    input  logic              res_taken,
    output logic              fb_valid,
    output logic              prediction_correct,
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              res_error,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic              taken;
        logic [ADDR_W-1:0] fallthru;
        logic [ADDR_W-1:0] target;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    logic   mis;
    entry_t head;

    // Handshake and compare decode for the current cycle.
    always_comb begin
        full       = (count == FULL_COUNT);
        empty      = (count == '0);
        pred_ready = !full;
        // Wrong-path fetches arrive while flush is high; they must not enter.
        push       = pred_valid && !full && !flush;
        pop        = res_valid && !empty;
        head       = mem[rd_ptr];
        mis        = pop && (head.taken ^ res_taken);
    end

    // Entry storage.
    // NOTE: the storage array carries no reset; occupancy and pointers alone
    // decide which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{taken: pred_taken, fallthru: pred_fallthru, target: pred_target};
        end
    end

    // Pointer and occupancy bookkeeping; a mispredict empties the queue.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (mis) begin
            // Younger entries and any same-cycle push are on the wrong path.
            rd_ptr <= rd_ptr + 1'b1;
            wr_ptr <= rd_ptr + 1'b1;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Registered feedback, flush/redirect and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_valid           <= 1'b0;
            prediction_correct <= 1'b0;
            flush              <= 1'b0;
            redirect_pc        <= '0;
            res_error          <= 1'b0;
        end else begin
            fb_valid           <= pop;
            prediction_correct <= pop && !mis;
            flush              <= mis;
            if (mis) begin
                redirect_pc <= res_taken ? head.target : head.fallthru;
            end
            if (res_valid && empty) begin
                res_error <= 1'b1;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (pop && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + 1'b1;
            end
            if (mis && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + 1'b1;
            end
        end
    end

endmodule
